// File: rtl/four_port_mux_pkg.sv
// Shared types and constants for the four-port request mux.
// Optional grant checker is enabled with FOUR_PORT_MUX_ONEHOT_CHK_EN (see four_port_req_mux).
package four_port_mux_pkg;

   localparam int NUM_PORTS = 4;
   localparam int DATA_W    = 64;

   typedef logic [1:0] port_id_t;

   typedef struct packed {
      port_id_t            port;
      logic [DATA_W-1:0]   data;
   } fifo_entry_t;

endpackage

// File: rtl/four_port_req_mux_if.sv
// Handshake bundle between the request mux, its input ports, the arbiter tree and the downstream channel.
// slave is the mux side; master is the side driving requests and grants.
interface four_port_req_mux_if #(
   parameter int DATA_W = four_port_mux_pkg::DATA_W
);
   logic [four_port_mux_pkg::NUM_PORTS-1:0]          in_valid;
   logic [four_port_mux_pkg::NUM_PORTS*DATA_W-1:0]   in_data;
   logic [four_port_mux_pkg::NUM_PORTS-1:0]          in_ready;
   logic [four_port_mux_pkg::NUM_PORTS-1:0]          arb_req;
   logic [four_port_mux_pkg::NUM_PORTS-1:0]          arb_grant;
   logic                                              arb_req_top;
   logic                                              arb_grant_top;
   logic                                              out_valid;
   logic [DATA_W-1:0]                                 out_data;
   logic [1:0]                                        out_port;
   logic                                              out_ready;
   logic                                              err_onehot;

   modport slave (
      input  in_valid, in_data, arb_grant, arb_req_top, out_ready,
      output in_ready, arb_req, arb_grant_top, out_valid, out_data, out_port, err_onehot
   );

   modport master (
      output in_valid, in_data, arb_grant, arb_req_top, out_ready,
      input  in_ready, arb_req, arb_grant_top, out_valid, out_data, out_port, err_onehot
   );
endinterface

// File: rtl/four_port_req_mux_out_fifo.sv
// Two-entry in-order output FIFO built from a head and a tail register.
// The head register is the output, so it keeps its last value when the FIFO drains.
module mux_out_fifo
   import four_port_mux_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  fifo_entry_t push_entry,
   input  logic        pop,
   output fifo_entry_t head,
   output logic        full,
   output logic        empty,
   output logic [1:0]  cnt
);
   fifo_entry_t head_reg;
   fifo_entry_t tail_reg;
   logic [1:0]  cnt_reg;
   logic        do_push;
   logic        do_pop;

   assign full    = (cnt_reg == 2'd2);
   assign empty   = (cnt_reg == 2'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg  <= 2'd0;
         head_reg <= '0;
         tail_reg <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (empty) head_reg <= push_entry;
               else       tail_reg <= push_entry;
               cnt_reg <= cnt_reg + 2'd1;
            end
            2'b01: begin
               // With a single entry the head just goes stale instead of loading the old tail.
               if (full) head_reg <= tail_reg;
               cnt_reg <= cnt_reg - 2'd1;
            end
            2'b11: begin
               // do_push excludes full, so the FIFO holds exactly one entry here.
               head_reg <= push_entry;
            end
            default: ;
         endcase
      end
   end

   assign head = head_reg;
   assign cnt  = cnt_reg;
endmodule

// File: rtl/four_port_req_mux.sv
// Per-port payload slots feeding a round-robin arbiter tree; granted payloads go to a 2-entry FIFO.
// Define FOUR_PORT_MUX_ONEHOT_CHK_EN to enable the sticky err_onehot flag and its assertion.
module four_port_req_mux
   import four_port_mux_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   four_port_req_mux_if.slave    bus
);
   logic [NUM_PORTS-1:0] slot_v;
   logic [DATA_W-1:0]    slot_d [NUM_PORTS];
   logic [NUM_PORTS-1:0] pop;
   logic [NUM_PORTS-1:0] cand;
   logic [NUM_PORTS-1:0] in_ready;
   logic                 grant_top;
   logic                 push;
   fifo_entry_t          push_entry;
   fifo_entry_t          head_entry;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [1:0]           fifo_cnt;
   logic                 fifo_pop;

   // A full FIFO refuses the grant even if the head leaves this cycle, keeping out_ready off this path.
   assign grant_top = bus.arb_req_top & ~fifo_full;
   assign cand      = bus.arb_grant & slot_v & {NUM_PORTS{grant_top}};

   // Lowest-index priority: a malformed multi-bit grant pops only one slot.
   always_comb begin
      pop        = '0;
      push_entry = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (cand[i]) begin
            pop             = '0;
            pop[i]          = 1'b1;
            push_entry.port = port_id_t'(i);
            push_entry.data = slot_d[i];
         end
      end
   end

   assign push     = |pop;
   assign in_ready = ~slot_v | pop;

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : gen_slot
         logic              slot_v_reg;
         logic [DATA_W-1:0] slot_d_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               slot_v_reg <= 1'b0;
               slot_d_reg <= '0;
            end else if (bus.in_valid[gi] & in_ready[gi]) begin
               slot_v_reg <= 1'b1;
               slot_d_reg <= bus.in_data[gi*DATA_W +: DATA_W];
            end else if (pop[gi]) begin
               slot_v_reg <= 1'b0;
            end
         end

         assign slot_v[gi] = slot_v_reg;
         assign slot_d[gi] = slot_d_reg;
      end
   endgenerate

   assign fifo_pop = (fifo_cnt != 2'd0) & bus.out_ready;

   mux_out_fifo u_out_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (fifo_pop),
      .head       (head_entry),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .cnt        (fifo_cnt)
   );

   assign bus.in_ready      = in_ready;
   assign bus.arb_req       = slot_v;
   assign bus.arb_grant_top = grant_top;
   assign bus.out_valid     = ~fifo_empty;
   assign bus.out_data      = head_entry.data;
   assign bus.out_port      = head_entry.port;

`ifdef FOUR_PORT_MUX_ONEHOT_CHK_EN
   logic multi_grant;
   logic err_onehot_reg;

   assign multi_grant = grant_top && ($countones(bus.arb_grant) > 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              err_onehot_reg <= 1'b0;
      else if (multi_grant) err_onehot_reg <= 1'b1;
   end

   assign bus.err_onehot = err_onehot_reg;

   a_grant_onehot: assert property (@(posedge clk) disable iff (rst) !multi_grant);
`else
   assign bus.err_onehot = 1'b0;
`endif
endmodule

// File: tb/tb_four_port_req_mux.sv
// Bench for four_port_req_mux: vector table, hand-written multi-cycle sequences, randomized run vs a queue model.
module tb_four_port_req_mux;
   import four_port_mux_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   four_port_req_mux_if bus ();

   four_port_req_mux dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0]  iv;
      logic [31:0] d8;
      logic [3:0]  g;
      logic        rt;
      logic        ordy;
      logic [3:0]  e_ready;
      logic [3:0]  e_req;
      logic        e_gt;
      logic        e_ov;
      logic [7:0]  e_data;
      logic [1:0]  e_port;
   } vec_t;

   vec_t vecs [9];

   // reference model state
   bit          m_sv [NUM_PORTS];
   logic [63:0] m_sd [NUM_PORTS];
   fifo_entry_t m_q [$];
   fifo_entry_t m_last;
   bit          m_err;

   fifo_entry_t got [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] pack4(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic [63:0] d);
      return {d, c, b, a};
   endfunction

   task automatic set_in(input logic [3:0] iv, input logic [255:0] d, input logic [3:0] g,
                         input logic rt, input logic ordy);
      bus.in_valid    = iv;
      bus.in_data     = d;
      bus.arb_grant   = g;
      bus.arb_req_top = rt;
      bus.out_ready   = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_PORTS; i++) begin
         m_sv[i] = 1'b0;
         m_sd[i] = '0;
      end
      m_q.delete();
      m_last = '0;
      m_err  = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      set_in(4'h0, '0, 4'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Compare this cycle's outputs to the model, then advance the model across the coming edge.
   task automatic model_check(input string tag);
      bit          gt;
      int          pidx;
      int          ones;
      logic [3:0]  e_ready;
      logic [3:0]  e_req;
      fifo_entry_t head;
      logic [76:0] e_vec;
      logic [76:0] a_vec;
      gt   = bus.arb_req_top && (m_q.size() < 2);
      pidx = -1;
      ones = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (bus.arb_grant[i]) ones++;
         if (gt && bus.arb_grant[i] && m_sv[i] && pidx < 0) pidx = i;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         e_req[i]   = m_sv[i];
         e_ready[i] = !m_sv[i] || (i == pidx);
      end
      head  = (m_q.size() != 0) ? m_q[0] : m_last;
      e_vec = {e_ready, e_req, gt, (m_q.size() != 0), head.port, head.data, m_err};
      a_vec = {bus.in_ready, bus.arb_req, bus.arb_grant_top, bus.out_valid,
               bus.out_port, bus.out_data, bus.err_onehot};
      check(tag, 128'(a_vec), 128'(e_vec));
`ifdef FOUR_PORT_MUX_ONEHOT_CHK_EN
      if (gt && ones > 1) m_err = 1'b1;
`endif
      if (m_q.size() != 0 && bus.out_ready) m_last = m_q.pop_front();
      if (pidx >= 0) begin
         m_q.push_back('{port: port_id_t'(pidx), data: m_sd[pidx]});
         m_sv[pidx] = 1'b0;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (bus.in_valid[i] && e_ready[i]) begin
            m_sv[i] = 1'b1;
            m_sd[i] = bus.in_data[i*64 +: 64];
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [255:0] d;
      logic [3:0]   r;
      logic [3:0]   g;
      logic [3:0]   gsel;
      logic         err_exp;
      int           pushes;
      int           stall;
      int           gaps;
      int           seen;

      vecs[0] = '{4'b0100, 32'h00A5_0000, 4'b0100, 1'b1, 1'b1, 4'hF,    4'b0000, 1'b1, 1'b0, 8'h00, 2'd0};
      vecs[1] = '{4'b0000, 32'h0000_0000, 4'b0100, 1'b1, 1'b1, 4'hF,    4'b0100, 1'b1, 1'b0, 8'h00, 2'd0};
      vecs[2] = '{4'b0000, 32'h0000_0000, 4'b0100, 1'b1, 1'b1, 4'hF,    4'b0000, 1'b1, 1'b1, 8'hA5, 2'd2};
      vecs[3] = '{4'b0011, 32'h0000_2211, 4'b0000, 1'b0, 1'b1, 4'hF,    4'b0000, 1'b0, 1'b0, 8'hA5, 2'd2};
      vecs[4] = '{4'b0000, 32'h0000_0000, 4'b0011, 1'b1, 1'b1, 4'b1101, 4'b0011, 1'b1, 1'b0, 8'hA5, 2'd2};
      vecs[5] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 4'b1101, 4'b0010, 1'b0, 1'b1, 8'h11, 2'd0};
      vecs[6] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 4'b1101, 4'b0010, 1'b0, 1'b0, 8'h11, 2'd0};
      vecs[7] = '{4'b0000, 32'h0000_0000, 4'b1000, 1'b1, 1'b1, 4'b1101, 4'b0010, 1'b1, 1'b0, 8'h11, 2'd0};
      vecs[8] = '{4'b0000, 32'h0000_0000, 4'b1000, 1'b1, 1'b1, 4'b1101, 4'b0010, 1'b1, 1'b0, 8'h11, 2'd0};

      // reset state
      rst = 1'b1;
      set_in(4'h0, '0, 4'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs",
            128'({bus.in_ready, bus.arb_req, bus.arb_grant_top, bus.out_valid, bus.out_port, bus.out_data, bus.err_onehot}),
            128'({4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 64'd0, 1'b0}));
      rst = 1'b0;
      model_reset();

      // single request, bad grant and ignored grant, cycle by cycle
      for (int k = 0; k < 9; k++) begin
         d = '0;
         for (int p = 0; p < NUM_PORTS; p++) d[p*64 +: 64] = {56'd0, vecs[k].d8[p*8 +: 8]};
         set_in(vecs[k].iv, d, vecs[k].g, vecs[k].rt, vecs[k].ordy);
         @(negedge clk);
         check($sformatf("vec[%0d]", k),
               128'({bus.in_ready, bus.arb_req, bus.arb_grant_top, bus.out_valid, bus.out_port, bus.out_data}),
               128'({vecs[k].e_ready, vecs[k].e_req, vecs[k].e_gt, vecs[k].e_ov, vecs[k].e_port, 56'd0, vecs[k].e_data}));
         tick();
      end
`ifdef FOUR_PORT_MUX_ONEHOT_CHK_EN
      err_exp = 1'b1;
`else
      err_exp = 1'b0;
`endif
      check("err_onehot_after_bad_grant", 128'(bus.err_onehot), 128'(err_exp));

      // backpressure: all four ports valid, downstream stalled
      do_reset();
      set_in(4'hF, pack4(64'h100, 64'h101, 64'h102, 64'h103), 4'h0, 1'b0, 1'b0);
      tick();
      pushes = 0;
      for (int c = 0; c < 6; c++) begin
         r = bus.arb_req;
         g = r & (~r + 4'd1);
         set_in(4'h0, '0, g, 1'b1, 1'b0);
         @(negedge clk);
         if (bus.arb_grant_top && ((g & bus.arb_req) != 4'h0)) pushes++;
         tick();
      end
      set_in(4'h0, '0, 4'b0100, 1'b1, 1'b0);
      @(negedge clk);
      check("bp_push_count", 128'(pushes), 128'(2));
      check("bp_full_state",
            128'({bus.arb_grant_top, bus.arb_req, bus.in_ready, bus.out_valid, bus.out_port}),
            128'({1'b0, 4'b1100, 4'b0011, 1'b1, 2'd0}));
      tick();
      got.delete();
      for (int c = 0; c < 12 && got.size() < 4; c++) begin
         r = bus.arb_req;
         g = r & (~r + 4'd1);
         set_in(4'h0, '0, g, 1'b1, 1'b1);
         @(negedge clk);
         if (c == 0) check("bp_full_no_grant_on_pop", 128'(bus.arb_grant_top), 128'(1'b0));
         if (bus.out_valid) got.push_back('{port: bus.out_port, data: bus.out_data});
         tick();
      end
      check("bp_drain_count", 128'(got.size()), 128'(4));
      for (int k = 0; k < got.size() && k < 4; k++)
         check($sformatf("bp_drain[%0d]", k), 128'({got[k].port, got[k].data}),
               128'({port_id_t'(k), 64'h100 + 64'(k)}));

      // full-rate single port
      do_reset();
      stall = 0;
      gaps  = 0;
      got.delete();
      for (int k = 0; k < 16; k++) begin
         set_in(4'b0010, pack4(64'd0, 64'h3000 + 64'(k), 64'd0, 64'd0), 4'b0010, 1'b1, 1'b1);
         @(negedge clk);
         if (!bus.in_ready[1]) stall++;
         if (k >= 2 && !bus.out_valid) gaps++;
         if (bus.out_valid) got.push_back('{port: bus.out_port, data: bus.out_data});
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         set_in(4'h0, '0, 4'b0010, 1'b1, 1'b1);
         @(negedge clk);
         if (bus.out_valid) got.push_back('{port: bus.out_port, data: bus.out_data});
         tick();
      end
      check("rate_in_ready_stalls", 128'(stall), 128'(0));
      check("rate_output_gaps", 128'(gaps), 128'(0));
      check("rate_count", 128'(got.size()), 128'(16));
      for (int k = 0; k < got.size() && k < 16; k++)
         check($sformatf("rate_word[%0d]", k), 128'({got[k].port, got[k].data}),
               128'({2'd1, 64'h3000 + 64'(k)}));

      // reset with FIFO full and three slots occupied
      do_reset();
      set_in(4'hF, pack4(64'h500, 64'h501, 64'h502, 64'h503), 4'h0, 1'b1, 1'b0);
      tick();
      set_in(4'b0001, pack4(64'h5AA, 64'd0, 64'd0, 64'd0), 4'b0001, 1'b1, 1'b0);
      tick();
      set_in(4'h0, '0, 4'b0010, 1'b1, 1'b0);
      tick();
      set_in(4'h0, '0, 4'h0, 1'b1, 1'b0);
      @(negedge clk);
      check("mid_pre_reset",
            128'({bus.arb_req, bus.out_valid, bus.arb_grant_top}),
            128'({4'b1101, 1'b1, 1'b0}));
      #1;
      rst = 1'b1;
      #1;
      check("mid_reset_outputs",
            128'({bus.out_valid, bus.arb_req, bus.in_ready, bus.out_data}),
            128'({1'b0, 4'h0, 4'hF, 64'd0}));
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         gsel = 4'b0001 << (c % 4);
         set_in(4'h0, '0, gsel, 1'b1, 1'b1);
         @(negedge clk);
         if (bus.out_valid) seen++;
         tick();
      end
      check("post_reset_no_stale_output", 128'(seen), 128'(0));

      // randomized traffic against the queue model
      for (int n = 0; n < 600; n++) begin
         d = '0;
         for (int p = 0; p < NUM_PORTS; p++) d[p*64 +: 64] = {$urandom, $urandom};
         gsel = ($urandom_range(0, 3) == 0) ? 4'h0 : (4'b0001 << $urandom_range(0, 3));
         set_in(4'($urandom), d, gsel, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
         @(negedge clk);
         model_check($sformatf("rand[%0d]", n));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
